// File: rtl/tl_ul_pkg.sv
// Shared TileLink-UL definitions: bus widths, opcode encodings and
// default-width beat structs used by the buffer and its users.
package tl_ul_pkg;

  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int MASK_W      = DATA_W / 8;
  localparam int TL_SOURCE_W = 4;

  // A-channel opcodes
  typedef enum logic [2:0] {
    TL_PUT_FULL    = 3'd0,
    TL_PUT_PARTIAL = 3'd1,
    TL_GET         = 3'd4
  } tl_a_op_e;

  // D-channel opcodes
  typedef enum logic [2:0] {
    TL_ACCESS_ACK      = 3'd0,
    TL_ACCESS_ACK_DATA = 3'd1
  } tl_d_op_e;

  // A-channel beat at the default source width
  typedef struct packed {
    logic [2:0]             opcode;
    logic [2:0]             param;
    logic [1:0]             size;
    logic [TL_SOURCE_W-1:0] source;
    logic [ADDR_W-1:0]      address;
    logic [MASK_W-1:0]      mask;
    logic [DATA_W-1:0]      data;
  } tl_a_t;

  // D-channel beat at the default source width
  typedef struct packed {
    logic [2:0]             opcode;
    logic [1:0]             size;
    logic [TL_SOURCE_W-1:0] source;
    logic                   denied;
    logic                   corrupt;
    logic [DATA_W-1:0]      data;
  } tl_d_t;

endpackage

// File: rtl/tl_fifo.sv
// Generic circular-buffer FIFO with registered occupancy. Ready and valid
// are derived from the count register only, so nothing on the output side
// reaches the input side combinationally. No flow-through.
module tl_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [3:0]       count
);

  localparam int              PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [3:0]       FULL_CNT = 4'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]       count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             push_s;
  logic             pop_s;
  logic             in_ready_s;
  logic             out_valid_s;

  // Explicit wrap so non-power-of-two depths return to slot 0
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] r;
    if (p == LAST_PTR) begin
      r = '0;
    end else begin
      r = p + PTR_W'(1);
    end
    return r;
  endfunction

  assign in_ready_s  = (count_q != FULL_CNT);
  assign out_valid_s = (count_q != 4'd0);
  assign push_s      = in_valid & in_ready_s;
  assign pop_s       = out_valid_s & out_ready;

  // Next-state for pointers, occupancy and storage
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (push_s) begin
      wr_ptr_d        = ptr_next(wr_ptr_q);
      mem_d[wr_ptr_q] = in_data;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = ptr_next(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
  end

  // Control state: reset discards every buffered beat
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 4'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage is intentionally left unreset
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_s;
  assign out_data  = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/tl_ul_buffer.sv
// Registered TL-UL buffer stage between the core-side port adapter and the
// crossbar. A and D channels are independent FIFOs with no ordering
// relation between them.
module tl_ul_buffer
  import tl_ul_pkg::*;
#(
  parameter int A_DEPTH  = 2,
  parameter int D_DEPTH  = 2,
  parameter int SOURCE_W = 4
) (
  input  logic                clock,
  input  logic                reset,
  // A channel from the core side
  input  logic                in_a_valid,
  output logic                in_a_ready,
  input  logic [2:0]          in_a_opcode,
  input  logic [2:0]          in_a_param,
  input  logic [1:0]          in_a_size,
  input  logic [SOURCE_W-1:0] in_a_source,
  input  logic [ADDR_W-1:0]   in_a_address,
  input  logic [MASK_W-1:0]   in_a_mask,
  input  logic [DATA_W-1:0]   in_a_data,
  // A channel toward the fabric
  output logic                out_a_valid,
  input  logic                out_a_ready,
  output logic [2:0]          out_a_opcode,
  output logic [2:0]          out_a_param,
  output logic [1:0]          out_a_size,
  output logic [SOURCE_W-1:0] out_a_source,
  output logic [ADDR_W-1:0]   out_a_address,
  output logic [MASK_W-1:0]   out_a_mask,
  output logic [DATA_W-1:0]   out_a_data,
  // D channel from the fabric
  input  logic                in_d_valid,
  output logic                in_d_ready,
  input  logic [2:0]          in_d_opcode,
  input  logic [1:0]          in_d_size,
  input  logic [SOURCE_W-1:0] in_d_source,
  input  logic                in_d_denied,
  input  logic                in_d_corrupt,
  input  logic [DATA_W-1:0]   in_d_data,
  // D channel toward the core
  output logic                out_d_valid,
  input  logic                out_d_ready,
  output logic [2:0]          out_d_opcode,
  output logic [1:0]          out_d_size,
  output logic [SOURCE_W-1:0] out_d_source,
  output logic                out_d_denied,
  output logic                out_d_corrupt,
  output logic [DATA_W-1:0]   out_d_data,
  // Occupancy
  output logic [3:0]          a_count,
  output logic [3:0]          d_count
);

  // Beat layouts at this instance's source width
  typedef struct packed {
    logic [2:0]          opcode;
    logic [2:0]          param;
    logic [1:0]          size;
    logic [SOURCE_W-1:0] source;
    logic [ADDR_W-1:0]   address;
    logic [MASK_W-1:0]   mask;
    logic [DATA_W-1:0]   data;
  } a_beat_t;

  typedef struct packed {
    logic [2:0]          opcode;
    logic [1:0]          size;
    logic [SOURCE_W-1:0] source;
    logic                denied;
    logic                corrupt;
    logic [DATA_W-1:0]   data;
  } d_beat_t;

  a_beat_t a_in_s, a_out_s;
  d_beat_t d_in_s, d_out_s;

  // Pack incoming A fields into one FIFO word
  always_comb begin
    a_in_s         = '0;
    a_in_s.opcode  = in_a_opcode;
    a_in_s.param   = in_a_param;
    a_in_s.size    = in_a_size;
    a_in_s.source  = in_a_source;
    a_in_s.address = in_a_address;
    a_in_s.mask    = in_a_mask;
    a_in_s.data    = in_a_data;
  end

  // Pack incoming D fields into one FIFO word
  always_comb begin
    d_in_s         = '0;
    d_in_s.opcode  = in_d_opcode;
    d_in_s.size    = in_d_size;
    d_in_s.source  = in_d_source;
    d_in_s.denied  = in_d_denied;
    d_in_s.corrupt = in_d_corrupt;
    d_in_s.data    = in_d_data;
  end

  tl_fifo #(
    .WIDTH ($bits(a_beat_t)),
    .DEPTH (A_DEPTH)
  ) u_a_fifo (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_a_valid),
    .in_ready  (in_a_ready),
    .in_data   (a_in_s),
    .out_valid (out_a_valid),
    .out_ready (out_a_ready),
    .out_data  (a_out_s),
    .count     (a_count)
  );

  tl_fifo #(
    .WIDTH ($bits(d_beat_t)),
    .DEPTH (D_DEPTH)
  ) u_d_fifo (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_d_valid),
    .in_ready  (in_d_ready),
    .in_data   (d_in_s),
    .out_valid (out_d_valid),
    .out_ready (out_d_ready),
    .out_data  (d_out_s),
    .count     (d_count)
  );

  assign out_a_opcode  = a_out_s.opcode;
  assign out_a_param   = a_out_s.param;
  assign out_a_size    = a_out_s.size;
  assign out_a_source  = a_out_s.source;
  assign out_a_address = a_out_s.address;
  assign out_a_mask    = a_out_s.mask;
  assign out_a_data    = a_out_s.data;

  assign out_d_opcode  = d_out_s.opcode;
  assign out_d_size    = d_out_s.size;
  assign out_d_source  = d_out_s.source;
  assign out_d_denied  = d_out_s.denied;
  assign out_d_corrupt = d_out_s.corrupt;
  assign out_d_data    = d_out_s.data;

endmodule

// File: tb/tb_tl_ul_buffer.sv
// Directed testbench for tl_ul_buffer. The D FIFO uses depth 3 so that the
// non-power-of-two pointer wrap is exercised during streaming.
module tb_tl_ul_buffer;

  localparam int A_DEPTH  = 2;
  localparam int D_DEPTH  = 3;
  localparam int SOURCE_W = 4;

  logic                clock;
  logic                reset;
  logic                in_a_valid, in_a_ready;
  logic [2:0]          in_a_opcode, in_a_param;
  logic [1:0]          in_a_size;
  logic [SOURCE_W-1:0] in_a_source;
  logic [31:0]         in_a_address;
  logic [3:0]          in_a_mask;
  logic [31:0]         in_a_data;
  logic                out_a_valid, out_a_ready;
  logic [2:0]          out_a_opcode, out_a_param;
  logic [1:0]          out_a_size;
  logic [SOURCE_W-1:0] out_a_source;
  logic [31:0]         out_a_address;
  logic [3:0]          out_a_mask;
  logic [31:0]         out_a_data;
  logic                in_d_valid, in_d_ready;
  logic [2:0]          in_d_opcode;
  logic [1:0]          in_d_size;
  logic [SOURCE_W-1:0] in_d_source;
  logic                in_d_denied, in_d_corrupt;
  logic [31:0]         in_d_data;
  logic                out_d_valid, out_d_ready;
  logic [2:0]          out_d_opcode;
  logic [1:0]          out_d_size;
  logic [SOURCE_W-1:0] out_d_source;
  logic                out_d_denied, out_d_corrupt;
  logic [31:0]         out_d_data;
  logic [3:0]          a_count, d_count;

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 1'b0;

  tl_ul_buffer #(
    .A_DEPTH  (A_DEPTH),
    .D_DEPTH  (D_DEPTH),
    .SOURCE_W (SOURCE_W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .in_a_valid    (in_a_valid),
    .in_a_ready    (in_a_ready),
    .in_a_opcode   (in_a_opcode),
    .in_a_param    (in_a_param),
    .in_a_size     (in_a_size),
    .in_a_source   (in_a_source),
    .in_a_address  (in_a_address),
    .in_a_mask     (in_a_mask),
    .in_a_data     (in_a_data),
    .out_a_valid   (out_a_valid),
    .out_a_ready   (out_a_ready),
    .out_a_opcode  (out_a_opcode),
    .out_a_param   (out_a_param),
    .out_a_size    (out_a_size),
    .out_a_source  (out_a_source),
    .out_a_address (out_a_address),
    .out_a_mask    (out_a_mask),
    .out_a_data    (out_a_data),
    .in_d_valid    (in_d_valid),
    .in_d_ready    (in_d_ready),
    .in_d_opcode   (in_d_opcode),
    .in_d_size     (in_d_size),
    .in_d_source   (in_d_source),
    .in_d_denied   (in_d_denied),
    .in_d_corrupt  (in_d_corrupt),
    .in_d_data     (in_d_data),
    .out_d_valid   (out_d_valid),
    .out_d_ready   (out_d_ready),
    .out_d_opcode  (out_d_opcode),
    .out_d_size    (out_d_size),
    .out_d_source  (out_d_source),
    .out_d_denied  (out_d_denied),
    .out_d_corrupt (out_d_corrupt),
    .out_d_data    (out_d_data),
    .a_count       (a_count),
    .d_count       (d_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge; outputs are then sampled 1 time unit later
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Invariants sampled on the falling edge, away from input changes
  logic        a_hold = 1'b0;
  logic        d_hold = 1'b0;
  logic [79:0] a_prev;
  logic [42:0] d_prev;
  always @(negedge clock) begin
    if (chk_en) begin
      n_tests++;
      if (out_a_valid !== (a_count != 4'd0) || out_d_valid !== (d_count != 4'd0)) begin
        n_fail++;
        $display("FAIL valid_vs_count: a_valid=%b a_count=%0d d_valid=%b d_count=%0d",
                 out_a_valid, a_count, out_d_valid, d_count);
      end
      n_tests++;
      if (a_count > 4'(A_DEPTH) || d_count > 4'(D_DEPTH)) begin
        n_fail++;
        $display("FAIL count_bound: a_count=%0d (max %0d) d_count=%0d (max %0d)",
                 a_count, A_DEPTH, d_count, D_DEPTH);
      end
      if (a_hold) begin
        n_tests++;
        if ({out_a_opcode, out_a_param, out_a_size, out_a_source, out_a_address,
             out_a_mask, out_a_data} !== a_prev) begin
          n_fail++;
          $display("FAIL a_stable: got %h required %h",
                   {out_a_opcode, out_a_param, out_a_size, out_a_source,
                    out_a_address, out_a_mask, out_a_data}, a_prev);
        end
      end
      if (d_hold) begin
        n_tests++;
        if ({out_d_opcode, out_d_size, out_d_source, out_d_denied, out_d_corrupt,
             out_d_data} !== d_prev) begin
          n_fail++;
          $display("FAIL d_stable: got %h required %h",
                   {out_d_opcode, out_d_size, out_d_source, out_d_denied,
                    out_d_corrupt, out_d_data}, d_prev);
        end
      end
      a_hold = out_a_valid & ~out_a_ready & ~reset;
      d_hold = out_d_valid & ~out_d_ready & ~reset;
      a_prev = {out_a_opcode, out_a_param, out_a_size, out_a_source, out_a_address,
                out_a_mask, out_a_data};
      d_prev = {out_d_opcode, out_d_size, out_d_source, out_d_denied, out_d_corrupt,
                out_d_data};
    end
  end

  task automatic test_reset();
    reset      = 1'b1;
    in_a_valid = 1'b1;
    in_d_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_en = 1'b1;
    end
    n_tests++;
    if (a_count !== 4'd0 || out_a_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: a_count=%0d out_a_valid=%b required 0/0", a_count, out_a_valid);
    end
    reset      = 1'b0;
    in_a_valid = 1'b0;
    in_d_valid = 1'b0;
    tick();
    n_tests++;
    if (out_a_valid !== 1'b0 || in_a_ready !== 1'b1 || a_count !== 4'd0 ||
        d_count !== 4'd0 || out_d_valid !== 1'b0 || in_d_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: av=%b ar=%b ac=%0d dv=%b dr=%b dc=%0d required 0 1 0 0 1 0",
               out_a_valid, in_a_ready, a_count, out_d_valid, in_d_ready, d_count);
    end
  endtask

  task automatic test_single_get();
    out_a_ready  = 1'b0;
    in_a_opcode  = 3'd4;
    in_a_param   = 3'd0;
    in_a_size    = 2'd2;
    in_a_source  = 4'd3;
    in_a_address = 32'h8000_0010;
    in_a_mask    = 4'hF;
    in_a_data    = 32'h0;
    in_a_valid   = 1'b1;
    tick();
    in_a_valid = 1'b0;
    n_tests++;
    if (out_a_valid !== 1'b1 || a_count !== 4'd1) begin
      n_fail++;
      $display("FAIL get_latency: out_a_valid=%b a_count=%0d required 1/1", out_a_valid, a_count);
    end
    n_tests++;
    if (out_a_opcode !== 3'd4 || out_a_source !== 4'd3 || out_a_address !== 32'h8000_0010 ||
        out_a_mask !== 4'hF || out_a_size !== 2'd2 || out_a_param !== 3'd0) begin
      n_fail++;
      $display("FAIL get_fields: op=%0d src=%0d addr=%h mask=%h size=%0d required 4 3 80000010 f 2",
               out_a_opcode, out_a_source, out_a_address, out_a_mask, out_a_size);
    end
    out_a_ready = 1'b1;
    tick();
    out_a_ready = 1'b0;
    n_tests++;
    if (a_count !== 4'd0 || out_a_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL get_drain: a_count=%0d out_a_valid=%b required 0/0", a_count, out_a_valid);
    end
  endtask

  task automatic test_backpressure();
    out_a_ready = 1'b0;
    in_a_opcode = 3'd0;
    in_a_mask   = 4'hF;
    in_a_valid  = 1'b1;
    in_a_data   = 32'h11;
    tick();
    in_a_data = 32'h22;
    tick();
    in_a_data = 32'h33;
    n_tests++;
    if (a_count !== 4'd2 || in_a_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_full: a_count=%0d in_a_ready=%b required 2/0", a_count, in_a_ready);
    end
    tick();
    n_tests++;
    if (a_count !== 4'd2 || out_a_data !== 32'h11) begin
      n_fail++;
      $display("FAIL bp_hold: a_count=%0d data=%h required 2/11", a_count, out_a_data);
    end
    out_a_ready = 1'b1;
    tick();
    n_tests++;
    if (a_count !== 4'd1 || out_a_data !== 32'h22 || in_a_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_pop1: a_count=%0d data=%h ready=%b required 1/22/1", a_count, out_a_data, in_a_ready);
    end
    tick();
    in_a_valid = 1'b0;
    n_tests++;
    if (a_count !== 4'd1 || out_a_data !== 32'h33) begin
      n_fail++;
      $display("FAIL bp_pop2: a_count=%0d data=%h required 1/33", a_count, out_a_data);
    end
    tick();
    out_a_ready = 1'b0;
    n_tests++;
    if (a_count !== 4'd0 || out_a_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_empty: a_count=%0d valid=%b required 0/0", a_count, out_a_valid);
    end
  endtask

  task automatic test_streaming();
    logic [31:0] i32;
    out_d_ready = 1'b1;
    in_d_opcode = 3'd1;
    in_d_size   = 2'd2;
    for (int i = 0; i < 16; i++) begin
      i32          = 32'(i);
      in_d_data    = i32;
      in_d_source  = i32[3:0];
      in_d_denied  = i32[0];
      in_d_corrupt = i32[1];
      in_d_valid   = 1'b1;
      tick();
      n_tests++;
      if (out_d_valid !== 1'b1 || out_d_data !== i32 || out_d_source !== i32[3:0] ||
          out_d_denied !== i32[0] || out_d_corrupt !== i32[1] || out_d_opcode !== 3'd1 ||
          d_count !== 4'd1) begin
        n_fail++;
        $display("FAIL stream_beat%0d: v=%b data=%h src=%0d den=%b cor=%b cnt=%0d required 1 %h %0d %b %b 1",
                 i, out_d_valid, out_d_data, out_d_source, out_d_denied, out_d_corrupt,
                 d_count, i32, i32[3:0], i32[0], i32[1]);
      end
    end
    in_d_valid = 1'b0;
    tick();
    n_tests++;
    if (out_d_valid !== 1'b0 || d_count !== 4'd0) begin
      n_fail++;
      $display("FAIL stream_end: v=%b cnt=%0d required 0/0", out_d_valid, d_count);
    end
    out_d_ready = 1'b0;
  endtask

  task automatic test_push_pop();
    out_a_ready = 1'b0;
    in_a_data   = 32'h100;
    in_a_valid  = 1'b1;
    tick();
    out_a_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      n_tests++;
      if (out_a_data !== 32'h100 + 32'(k)) begin
        n_fail++;
        $display("FAIL pp_order%0d: data=%h required %h", k, out_a_data, 32'h100 + 32'(k));
      end
      in_a_data = 32'h101 + 32'(k);
      tick();
      n_tests++;
      if (a_count !== 4'd1) begin
        n_fail++;
        $display("FAIL pp_count%0d: a_count=%0d required 1", k, a_count);
      end
    end
    in_a_valid = 1'b0;
    n_tests++;
    if (out_a_data !== 32'h108) begin
      n_fail++;
      $display("FAIL pp_last: data=%h required 108", out_a_data);
    end
    tick();
    out_a_ready = 1'b0;
    n_tests++;
    if (a_count !== 4'd0) begin
      n_fail++;
      $display("FAIL pp_drain: a_count=%0d required 0", a_count);
    end
  endtask

  task automatic test_mid_reset();
    out_a_ready = 1'b0;
    out_d_ready = 1'b0;
    in_a_data   = 32'hAA1;
    in_a_valid  = 1'b1;
    in_d_data   = 32'hDD1;
    in_d_valid  = 1'b1;
    tick();
    in_a_data  = 32'hAA2;
    in_d_valid = 1'b0;
    tick();
    in_a_valid = 1'b0;
    n_tests++;
    if (a_count !== 4'd2 || d_count !== 4'd1) begin
      n_fail++;
      $display("FAIL mr_pre: a_count=%0d d_count=%0d required 2/1", a_count, d_count);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_tests++;
    if (a_count !== 4'd0 || d_count !== 4'd0 || out_a_valid !== 1'b0 ||
        out_d_valid !== 1'b0 || in_a_ready !== 1'b1 || in_d_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mr_cleared: ac=%0d dc=%0d av=%b dv=%b ar=%b dr=%b required 0 0 0 0 1 1",
               a_count, d_count, out_a_valid, out_d_valid, in_a_ready, in_d_ready);
    end
    out_a_ready = 1'b1;
    out_d_ready = 1'b1;
    tick();
    n_tests++;
    if (out_a_valid !== 1'b0 || out_d_valid !== 1'b0 || a_count !== 4'd0 || d_count !== 4'd0) begin
      n_fail++;
      $display("FAIL mr_no_ghost: av=%b dv=%b ac=%0d dc=%0d required 0 0 0 0",
               out_a_valid, out_d_valid, a_count, d_count);
    end
    out_a_ready = 1'b0;
    in_a_data   = 32'h5555;
    in_a_valid  = 1'b1;
    tick();
    in_a_valid = 1'b0;
    n_tests++;
    if (out_a_data !== 32'h5555 || a_count !== 4'd1) begin
      n_fail++;
      $display("FAIL mr_fresh: data=%h a_count=%0d required 5555/1", out_a_data, a_count);
    end
    out_a_ready = 1'b1;
    tick();
    out_a_ready = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    in_a_valid   = 1'b0;
    in_a_opcode  = 3'd0;
    in_a_param   = 3'd0;
    in_a_size    = 2'd0;
    in_a_source  = '0;
    in_a_address = 32'h0;
    in_a_mask    = 4'h0;
    in_a_data    = 32'h0;
    out_a_ready  = 1'b0;
    in_d_valid   = 1'b0;
    in_d_opcode  = 3'd0;
    in_d_size    = 2'd0;
    in_d_source  = '0;
    in_d_denied  = 1'b0;
    in_d_corrupt = 1'b0;
    in_d_data    = 32'h0;
    out_d_ready  = 1'b0;

    test_reset();
    test_single_get();
    test_backpressure();
    test_streaming();
    test_push_pop();
    test_mid_reset();

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
